// File: rtl/conv_pkg.sv
// Shared definitions for the convolution tap issuer: default sizes, the FSM
// state type, the accumulator width rule and address range helpers.
package conv_pkg;

    localparam int DEF_INPUT  = 4;   // pixel width, unsigned
    localparam int DEF_FILTER = 4;   // weight width, signed
    localparam int DEF_IMG    = 4;   // image side
    localparam int DEF_K      = 2;   // kernel side

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        EMIT,
        DONE
    } state_e;

    // Accumulator wide enough for K*K worst-case products without overflow.
    function automatic int acc_width(input int in_w, input int flt_w, input int k);
        return in_w + flt_w + $clog2(k * k);
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic img_addr_ok(input int unsigned addr, input int img);
        return addr < $unsigned(img * img);
    endfunction

    function automatic logic flt_addr_ok(input int unsigned addr, input int k);
        return addr < $unsigned(k * k);
    endfunction

endpackage

// File: rtl/conv_window_addr_gen.sv
// Window walker: output-position and tap counters, producing the image and
// filter read indices for the current tap plus first/last flags.
module conv_window_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG = DEF_IMG,
    parameter int K   = DEF_K
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear_i,
    input  logic                          tap_adv_i,
    input  logic                          pos_adv_i,
    output logic [$clog2(IMG*IMG)-1:0]    img_idx_o,
    output logic [idx_width(K*K)-1:0]     flt_idx_o,
    output logic [$clog2(IMG)-1:0]        pos_row_o,
    output logic [$clog2(IMG)-1:0]        pos_col_o,
    output logic                          tap_first_o,
    output logic                          last_tap_o,
    output logic                          last_pos_o
);

    localparam int ADDR_W  = $clog2(IMG * IMG);
    localparam int FADDR_W = idx_width(K * K);
    localparam int POS_W   = $clog2(IMG);
    localparam int TAP_W   = idx_width(K);
    localparam int NPOS    = IMG - K + 1;

    logic [TAP_W-1:0] tap_i_q, tap_i_d;
    logic [TAP_W-1:0] tap_j_q, tap_j_d;
    logic [POS_W-1:0] pos_row_q, pos_row_d;
    logic [POS_W-1:0] pos_col_q, pos_col_d;
    logic [ADDR_W-1:0] pix_row, pix_col;

    // Counter next-state: taps walk the kernel in raster order, positions walk the output grid.
    // NOTE: every _d gets its hold value first, so no branch can leave it unassigned and infer a latch.
    always_comb begin
        tap_i_d   = tap_i_q;
        tap_j_d   = tap_j_q;
        pos_row_d = pos_row_q;
        pos_col_d = pos_col_q;
        if (clear_i) begin
            tap_i_d   = '0;
            tap_j_d   = '0;
            pos_row_d = '0;
            pos_col_d = '0;
        end else begin
            if (tap_adv_i) begin
                if (tap_j_q == TAP_W'(K - 1)) begin
                    tap_j_d = '0;
                    tap_i_d = (tap_i_q == TAP_W'(K - 1)) ? '0 : tap_i_q + TAP_W'(1);
                end else begin
                    tap_j_d = tap_j_q + TAP_W'(1);
                end
            end
            if (pos_adv_i) begin
                if (pos_col_q == POS_W'(NPOS - 1)) begin
                    pos_col_d = '0;
                    pos_row_d = pos_row_q + POS_W'(1);
                end else begin
                    pos_col_d = pos_col_q + POS_W'(1);
                end
            end
        end
    end

    // Counter registers with synchronous reset.
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tap_i_q   <= '0;
            tap_j_q   <= '0;
            pos_row_q <= '0;
            pos_col_q <= '0;
        end else begin
            tap_i_q   <= tap_i_d;
            tap_j_q   <= tap_j_d;
            pos_row_q <= pos_row_d;
            pos_col_q <= pos_col_d;
        end
    end

    assign pix_row   = ADDR_W'(pos_row_q) + ADDR_W'(tap_i_q);
    assign pix_col   = ADDR_W'(pos_col_q) + ADDR_W'(tap_j_q);
    assign img_idx_o = pix_row * ADDR_W'(IMG) + pix_col;
    assign flt_idx_o = FADDR_W'(tap_i_q) * FADDR_W'(K) + FADDR_W'(tap_j_q);

    assign pos_row_o   = pos_row_q;
    assign pos_col_o   = pos_col_q;
    assign tap_first_o = (tap_i_q == '0) && (tap_j_q == '0);
    assign last_tap_o  = (tap_i_q == TAP_W'(K - 1)) && (tap_j_q == TAP_W'(K - 1));
    assign last_pos_o  = (pos_row_q == POS_W'(NPOS - 1)) && (pos_col_q == POS_W'(NPOS - 1));

endmodule

// File: rtl/conv_tap_issuer.sv
// Convolution tap issuer: holds an image and a filter, feeds one pixel/weight
// pair per cycle to an external combinational multiplier, accumulates the
// products and hands out one result per output position over valid/ready.
module conv_tap_issuer
    import conv_pkg::*;
#(
    parameter int INPUT  = DEF_INPUT,
    parameter int FILTER = DEF_FILTER,
    parameter int IMG    = DEF_IMG,
    parameter int K      = DEF_K,
    parameter int ACC_W  = acc_width(INPUT, FILTER, K)
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        load_en,
    input  logic                                        load_sel,
    input  logic [$clog2(IMG*IMG)-1:0]                  load_addr,
    input  logic [((INPUT > FILTER) ? INPUT : FILTER)-1:0] load_data,
    input  logic                                        go,
    output logic                                        busy,
    output logic                                        mul_start,
    output logic [INPUT-1:0]                            mul_din0,
    output logic [FILTER-1:0]                           mul_din1,
    input  logic [INPUT+FILTER-1:0]                     mul_dout,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [ACC_W-1:0]                            out_data,
    output logic [$clog2(IMG)-1:0]                      out_row,
    output logic [$clog2(IMG)-1:0]                      out_col,
    output logic                                        done
);

    localparam int ADDR_W  = $clog2(IMG * IMG);
    localparam int FADDR_W = idx_width(K * K);
    localparam int POS_W   = $clog2(IMG);

    state_e state_q, state_d;

    logic [INPUT-1:0]  img_mem [IMG*IMG];
    logic [FILTER-1:0] flt_mem [K*K];

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] prod_ext;

    logic [ADDR_W-1:0]  img_idx;
    logic [FADDR_W-1:0] flt_idx;
    logic [POS_W-1:0]   pos_row, pos_col;
    logic               tap_first, last_tap, last_pos;
    logic               ctr_clear, tap_adv, pos_adv;
    logic               idle;

    assign idle     = (state_q == IDLE);
    assign busy     = !idle;
    assign prod_ext = ACC_W'($signed(mul_dout));

    conv_window_addr_gen #(
        .IMG (IMG),
        .K   (K)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (ctr_clear),
        .tap_adv_i   (tap_adv),
        .pos_adv_i   (pos_adv),
        .img_idx_o   (img_idx),
        .flt_idx_o   (flt_idx),
        .pos_row_o   (pos_row),
        .pos_col_o   (pos_col),
        .tap_first_o (tap_first),
        .last_tap_o  (last_tap),
        .last_pos_o  (last_pos)
    );

    // Image/filter register files: written only while idle, frozen during a run.
    // NOTE: the arrays have no reset, so a mid-run abort keeps the loaded image and filter.
    always_ff @(posedge clk) begin
        if (load_en && idle) begin
            if (!load_sel && img_addr_ok(32'(load_addr), IMG)) begin
                img_mem[load_addr] <= load_data[INPUT-1:0];
            end else if (load_sel && flt_addr_ok(32'(load_addr), K)) begin
                flt_mem[load_addr[FADDR_W-1:0]] <= load_data[FILTER-1:0];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulator: first tap of a window loads, later taps add.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (state_q == ISSUE) begin
            acc_q <= tap_first ? prod_ext : acc_q + prod_ext;
        end
    end

    // Next-state logic plus multiplier and result port values.
    always_comb begin
        state_d   = state_q;
        ctr_clear = 1'b0;
        tap_adv   = 1'b0;
        pos_adv   = 1'b0;
        mul_start = 1'b0;
        mul_din0  = '0;
        mul_din1  = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_row   = '0;
        out_col   = '0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    ctr_clear = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                mul_din0  = img_mem[img_idx];
                mul_din1  = flt_mem[flt_idx];
                tap_adv   = 1'b1;
                if (last_tap) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_data  = acc_q;
                out_row   = pos_row;
                out_col   = pos_col;
                if (out_ready) begin
                    if (last_pos) begin
                        state_d = DONE;
                    end else begin
                        pos_adv = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv_tap_issuer.sv
// Directed bench for conv_tap_issuer: stimulus pushes hand-computed results
// into a scoreboard queue, a negedge monitor pops and compares on every
// accepted output.
module tb_conv_tap_issuer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic        load_sel;
    logic [3:0]  load_addr;
    logic [3:0]  load_data;
    logic        go;
    logic        busy;
    logic        mul_start;
    logic [3:0]  mul_din0;
    logic [3:0]  mul_din1;
    logic [7:0]  mul_dout;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_data;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        done;

    conv_tap_issuer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .load_sel  (load_sel),
        .load_addr (load_addr),
        .load_data (load_data),
        .go        (go),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .done      (done)
    );

    always #5 clk = ~clk;

    // External combinational multiplier: unsigned pixel times signed weight.
    logic signed [7:0] pix_s, wgt_s;
    assign pix_s    = {4'b0000, mul_din0};
    assign wgt_s    = {{4{mul_din1[3]}}, mul_din1};
    assign mul_dout = pix_s * wgt_s;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        int data;
        int row;
        int col;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;
    int   n_results = 0;
    int   n_dones   = 0;
    int   n_mul     = 0;
    bit   chk_mul   = 1'b0;
    int   mul_exp   = 0;

    // Monitor: compare every accepted result against the scoreboard, count done and taps.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", $signed(out_data), 32'sd9999);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("out_data", $signed(out_data), exp_e.data);
                    check("out_row", out_row, exp_e.row);
                    check("out_col", out_col, exp_e.col);
                end
                n_results++;
            end
            if (done) n_dones++;
            if (mul_start) begin
                n_mul++;
                if (chk_mul) check("mul_dout", $signed(mul_dout), mul_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input int addr, input int data);
        load_en   = 1'b1;
        load_sel  = sel;
        load_addr = 4'(addr);
        load_data = 4'(data);
        tick();
        load_en   = 1'b0;
    endtask

    task automatic load_image_const(input int val);
        for (int a = 0; a < 16; a++) load(1'b0, a, val);
    endtask

    task automatic load_filter_const(input int val);
        for (int a = 0; a < 4; a++) load(1'b1, a, val);
    endtask

    task automatic push_all(input int val);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                exp_q.push_back('{data: val, row: r, col: c});
    endtask

    task automatic start_run();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300; i++) begin
            if (done) break;
            tick();
        end
        check({name, "_done"}, done, 1);
        tick();
    endtask

    // Launch a run whose expectations are already queued, then check totals.
    task automatic run_and_check(input string name);
        int r0, d0;
        r0 = n_results;
        d0 = n_dones;
        start_run();
        wait_done(name);
        check({name, "_results"}, n_results - r0, 9);
        check({name, "_dones"}, n_dones - d0, 1);
        check({name, "_queue_left"}, exp_q.size(), 0);
        check({name, "_busy_after"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int lat, r0, m0, d0;
        rst_n     = 1'b0;
        load_en   = 1'b0;
        load_sel  = 1'b0;
        load_addr = '0;
        load_data = '0;
        go        = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        // Reset values
        check("rst_busy", busy, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_out_data", $signed(out_data), 0);
        check("rst_mul_din0", mul_din0, 0);
        check("rst_mul_din1", mul_din1, 0);
        check("rst_out_row", out_row, 0);
        rst_n = 1'b1;
        tick();

        // Test 1: all ones -> every result 4, plus first-result latency
        load_image_const(1);
        load_filter_const(1);
        push_all(4);
        r0 = n_results;
        d0 = n_dones;
        start_run();
        check("t1_busy", busy, 1);
        lat = 1;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("t1_latency", lat, 5);
        wait_done("t1");
        check("t1_results", n_results - r0, 9);
        check("t1_dones", n_dones - d0, 1);
        check("t1_queue_left", exp_q.size(), 0);

        // Test 2: max pixel times most negative weight, no wrap
        load_image_const(15);
        load_filter_const(8);
        push_all(-480);
        chk_mul = 1'b1;
        mul_exp = -120;
        run_and_check("t2");
        chk_mul = 1'b0;

        // Test 3: raster image with diagonal difference filter
        for (int a = 0; a < 16; a++) load(1'b0, a, a);
        load(1'b1, 0, 1);
        load(1'b1, 1, 0);
        load(1'b1, 2, 0);
        load(1'b1, 3, 15);
        push_all(-5);
        run_and_check("t3");

        // Test 4: consumer stall during EMIT
        load_image_const(1);
        load_filter_const(1);
        push_all(4);
        m0 = n_mul;
        r0 = n_results;
        start_run();
        for (int i = 0; i < 50; i++) begin
            if (out_valid) break;
            tick();
        end
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("t4_stall_valid", out_valid, 1);
            check("t4_stall_data", $signed(out_data), 4);
            check("t4_stall_row", out_row, 0);
            check("t4_stall_col", out_col, 0);
            check("t4_stall_mul_start", mul_start, 0);
        end
        check("t4_taps_during_stall", n_mul - m0, 4);
        out_ready = 1'b1;
        wait_done("t4");
        check("t4_results", n_results - r0, 9);
        check("t4_total_taps", n_mul - m0, 36);

        // Test 5: go and loads while busy are ignored
        push_all(4);
        r0 = n_results;
        d0 = n_dones;
        start_run();
        tick();
        go        = 1'b1;
        load_en   = 1'b1;
        load_sel  = 1'b0;
        load_addr = 4'd5;
        load_data = 4'd9;
        tick();
        load_sel  = 1'b1;
        load_addr = 4'd0;
        load_data = 4'd7;
        tick();
        go        = 1'b0;
        load_en   = 1'b0;
        wait_done("t5");
        check("t5_results", n_results - r0, 9);
        check("t5_dones", n_dones - d0, 1);
        check("t5_queue_left", exp_q.size(), 0);

        // Load and go in the same idle cycle: the run sees the new pixel
        exp_q.push_back('{data: 8, row: 0, col: 0});
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (r != 0 || c != 0) exp_q.push_back('{data: 4, row: r, col: c});
        load_en   = 1'b1;
        load_sel  = 1'b0;
        load_addr = 4'd0;
        load_data = 4'd5;
        go        = 1'b1;
        tick();
        load_en   = 1'b0;
        go        = 1'b0;
        wait_done("t5b");
        check("t5b_queue_left", exp_q.size(), 0);

        // Restore pixel 0; an out-of-range filter write must not alias into the filter
        load(1'b0, 0, 1);
        load(1'b1, 4, 7);

        // Test 6: reset on the third position's second tap
        push_all(4);
        r0 = n_results;
        start_run();
        for (int i = 0; i < 100; i++) begin
            if ((n_results - r0) == 2 && mul_start) break;
            tick();
        end
        check("t6_reached_pos2", n_results - r0, 2);
        tick();
        rst_n = 1'b0;
        tick();
        check("t6_busy", busy, 0);
        check("t6_out_valid", out_valid, 0);
        check("t6_mul_start", mul_start, 0);
        check("t6_mul_din0", mul_din0, 0);
        d0 = n_dones;
        rst_n = 1'b1;
        exp_q.delete();
        repeat (6) tick();
        check("t6_no_done", n_dones - d0, 0);
        push_all(4);
        run_and_check("t6_rerun");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
